qea_run_controller: RTL
=======================

QEA_RUN_CONTROLLER -- requirements
Module: qea_run_controller

Interface
REQ-001 Parameters SHALL be, as name, default, meaning:
- PE_NUM, 4, PE lanes per state word.
- STATE_DATA_WIDTH, 64, complex amplitude width: real part in the upper half, imaginary part in the lower half.
- STATE_ADDR_WIDTH, 16, state RAM address width.
- GATE_CONTEXT_ADDR_WIDTH, 16, context RAM address width.
- GATE_CONTEXT_DATA_WIDTH, 64, context word width.
- MAX_QBIT_WIDTH, 6, qubit-count width.
- NUM_FRAC_BIT, 30, fixed-point fraction bits.
- CNT_WIDTH, 32, cycle counter and timeout width.

REQ-002 Ports SHALL be, as name, direction, width, meaning:
- clk, in, 1, single clock; all logic is on the rising edge.
- rst, in, 1, synchronous active-high reset.
- i_run, in, 1, one-cycle request to launch a job.
- i_qbit_num, in, MAX_QBIT_WIDTH, qubit count; sampled on i_run.
- i_ins_num, in, GATE_CONTEXT_ADDR_WIDTH, number of context words; sampled on i_run.
- i_timeout, in, CNT_WIDTH, execution cycle limit, 0 = none; sampled on i_run.
- i_ctx_valid, in, 1, context stream valid.
- i_ctx_data, in, GATE_CONTEXT_DATA_WIDTH, context stream word.
- o_ctx_ready, out, 1, context stream ready.
- o_ctx_en, o_ctx_wea, out, 1 each, QEA context RAM enable and write.
- o_ctx_addr, out, GATE_CONTEXT_ADDR_WIDTH, context RAM address.
- o_ctx_data, out, GATE_CONTEXT_DATA_WIDTH, context RAM data.
- o_state_ena, o_state_wea, out, PE_NUM each, per-lane state RAM enable and write.
- o_state_addra, out, STATE_ADDR_WIDTH, state RAM address.
- o_state_dina, out, PE_NUM*STATE_DATA_WIDTH, state RAM data.
- i_state_dout, in, PE_NUM*STATE_DATA_WIDTH, QEA state readback.
- o_qea_start, out, 1, QEA start pulse.
- o_qea_qbit_num, out, MAX_QBIT_WIDTH, latched qubit count.
- i_qea_complete, in, 1, QEA completion.
- o_res_valid, out, 1, readback word valid.
- o_res_addr, out, STATE_ADDR_WIDTH, readback word address.
- o_res_data, out, PE_NUM*STATE_DATA_WIDTH, readback word data.
- o_busy, out, 1, a job is in progress.
- o_done, out, 1, one-cycle job-success pulse.
- o_err, out, 1, sticky until the next accepted i_run: bad qubit count.
- o_timeout, out, 1, sticky until the next accepted i_run: execution timed out.
- o_cycles, out, CNT_WIDTH, execution cycle count.

Function
REQ-003 The FSM SHALL have the states IDLE, LOAD_CTX, LOAD_STATE, START, WAIT, READ, DRAIN, DONE and ERR.

REQ-004 In IDLE, i_run SHALL latch its three sampled inputs, clear o_err, o_timeout and o_cycles, and go to:
- ERR if q<2 or q>STATE_ADDR_WIDTH+2;
- otherwise LOAD_STATE if i_ins_num=0;
- otherwise LOAD_CTX.

REQ-005 i_run asserted outside IDLE SHALL be ignored.

REQ-006 o_busy SHALL be 1 in every state except IDLE.

REQ-007 In LOAD_CTX, o_ctx_ready SHALL be 1.
- Each cycle with i_ctx_valid high writes i_ctx_data: o_ctx_en=o_ctx_wea=1 and o_ctx_addr=k, where k starts at 0 and increments per accepted word.
- With i_ctx_valid low, o_ctx_en=0.
- After the word at k=ins_num-1 is accepted, the FSM goes to LOAD_STATE.

REQ-008 LOAD_STATE SHALL write N=2^(q-2) words at addresses 0..N-1, one per cycle.
- o_state_ena and o_state_wea are all ones.
- Address 0 holds 1.0 (value 1<<NUM_FRAC_BIT) in the real half of the most significant lane; every other bit of every word is 0.
- The state lasts exactly N cycles, then the FSM goes to START.

REQ-009 START SHALL assert o_qea_start for exactly one cycle, then go to WAIT.

REQ-010 In WAIT, o_cycles SHALL increment every cycle, saturating at all-ones, including the cycle in which i_qea_complete is sampled high.
- i_qea_complete is sampled only in WAIT, so it has no effect in START.
- i_qea_complete=1 goes to READ.
- If i_timeout≠0 and o_cycles reaches i_timeout without completion, the FSM sets o_timeout and goes to ERR.
- When complete and the limit coincide in the same cycle, complete wins.

REQ-011 In READ, the block SHALL issue addresses 0..N-1, one per cycle, with o_state_ena all ones and o_state_wea=0, then spend 1 cycle in DRAIN.

REQ-012 Readback SHALL have one-cycle latency: the cycle after address a is issued, o_res_valid=1, o_res_addr=a and o_res_data=i_state_dout.
- Exactly N valid words are produced, with no gaps.
- There is no backpressure.

REQ-013 DONE SHALL pulse o_done for one cycle and return to IDLE.

REQ-014 ERR SHALL hold for one cycle, drive all RAM enables to 0, and return to IDLE, leaving o_err or o_timeout set.

REQ-015 o_qea_qbit_num SHALL hold the latched q from acceptance until the next accepted i_run.

REQ-016 Address counters SHALL NOT wrap: the termination compare happens on the last index.

REQ-017 Enables, write strobes and o_res_valid SHALL be 0 in every state not listed for them.

Reset
REQ-018 With rst=1 at a clock edge, all registers SHALL take their reset values at that edge, regardless of state:
- FSM = IDLE;
- every output = 0, including o_ctx_ready, o_qea_start, o_busy, o_done, o_err, o_timeout, o_cycles and o_qea_qbit_num;
- latched q = 0.

REQ-019 A reset mid-job SHALL abandon the job: no further RAM writes, start or result output until a new i_run.

Verification
REQ-020 The bench SHALL cover the following scenarios:
- (a) Reset held 3 cycles, then released -> all outputs 0 and o_busy=0.
- (b) q=8, ins_num=209, context stream with random valid gaps, i_qea_complete raised 1000 cycles after start -> 209 context writes to addresses 0..208 in order; 64 state writes, address 0 = 0x40000000_00000000 in the top lane and zeros elsewhere; one start pulse; o_cycles=1000; 64 results at addresses 0..63; one o_done.
- (c) q=1 -> o_err=1 and the FSM returns to IDLE; no RAM writes and no o_qea_start.
- (d) q=4, ins_num=0, i_timeout=50, complete never raised -> LOAD_CTX is skipped; 4 state writes; o_timeout=1 after 50 WAIT cycles; no results.
- (e) rst pulsed during LOAD_STATE -> all enables 0 on the next cycle; a subsequent q=2 job completes normally with exactly 1 state write and 1 result.
- (f) i_run repeated during WAIT, and complete sampled high on the cycle the timeout is reached -> the second i_run is ignored; READ proceeds; o_timeout=0.

Source files
------------

// File: rtl/qea_run_controller.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : qea_run_controller                                            |
// | Brief    : Job sequencer for the QEA core. Loads gate context words,     |
// |            initialises the state RAM to |0...0>, starts the core, waits  |
// |            for completion (with an optional cycle limit) and streams the |
// |            final state vector back out.                                  |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module qea_run_controller #(
    parameter int PE_NUM                  = 4,
    parameter int STATE_DATA_WIDTH        = 64,
    parameter int STATE_ADDR_WIDTH        = 16,
    parameter int GATE_CONTEXT_ADDR_WIDTH = 16,
    parameter int GATE_CONTEXT_DATA_WIDTH = 64,
    parameter int MAX_QBIT_WIDTH          = 6,
    parameter int NUM_FRAC_BIT            = 30,
    parameter int CNT_WIDTH               = 32
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 i_run,
    input  logic [MAX_QBIT_WIDTH-1:0]            i_qbit_num,
    input  logic [GATE_CONTEXT_ADDR_WIDTH-1:0]   i_ins_num,
    input  logic [CNT_WIDTH-1:0]                 i_timeout,
    input  logic                                 i_ctx_valid,
    input  logic [GATE_CONTEXT_DATA_WIDTH-1:0]   i_ctx_data,
    output logic                                 o_ctx_ready,
    output logic                                 o_ctx_en,
    output logic                                 o_ctx_wea,
    output logic [GATE_CONTEXT_ADDR_WIDTH-1:0]   o_ctx_addr,
    output logic [GATE_CONTEXT_DATA_WIDTH-1:0]   o_ctx_data,
    output logic [PE_NUM-1:0]                    o_state_ena,
    output logic [PE_NUM-1:0]                    o_state_wea,
    output logic [STATE_ADDR_WIDTH-1:0]          o_state_addra,
    output logic [PE_NUM*STATE_DATA_WIDTH-1:0]   o_state_dina,
    input  logic [PE_NUM*STATE_DATA_WIDTH-1:0]   i_state_dout,
    output logic                                 o_qea_start,
    output logic [MAX_QBIT_WIDTH-1:0]            o_qea_qbit_num,
    input  logic                                 i_qea_complete,
    output logic                                 o_res_valid,
    output logic [STATE_ADDR_WIDTH-1:0]          o_res_addr,
    output logic [PE_NUM*STATE_DATA_WIDTH-1:0]   o_res_data,
    output logic                                 o_busy,
    output logic                                 o_done,
    output logic                                 o_err,
    output logic                                 o_timeout,
    output logic [CNT_WIDTH-1:0]                 o_cycles
);

    localparam int c_word_w  = PE_NUM * STATE_DATA_WIDTH;
    // 1.0 sits in the real (upper) half of the most significant lane
    localparam int c_one_bit = c_word_w - STATE_DATA_WIDTH / 2 + NUM_FRAC_BIT;
    localparam logic [c_word_w-1:0] c_one_word = {{(c_word_w - 1){1'b0}}, 1'b1} << c_one_bit;

    localparam logic [MAX_QBIT_WIDTH-1:0]          c_q_min   = MAX_QBIT_WIDTH'(2);
    localparam logic [MAX_QBIT_WIDTH-1:0]          c_q_max   = MAX_QBIT_WIDTH'(STATE_ADDR_WIDTH + 2);
    localparam logic [GATE_CONTEXT_ADDR_WIDTH-1:0] c_ctx_one = GATE_CONTEXT_ADDR_WIDTH'(1);
    localparam logic [STATE_ADDR_WIDTH-1:0]        c_st_one  = STATE_ADDR_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0]               c_cnt_one = CNT_WIDTH'(1);

    typedef enum logic [3:0] {
        S_IDLE       = 4'd0,
        S_LOAD_CTX   = 4'd1,
        S_LOAD_STATE = 4'd2,
        S_START      = 4'd3,
        S_WAIT       = 4'd4,
        S_READ       = 4'd5,
        S_DRAIN      = 4'd6,
        S_DONE       = 4'd7,
        S_ERR        = 4'd8
    } state_t;

    state_t                               state_q,     state_d;
    logic [MAX_QBIT_WIDTH-1:0]            qbit_q,      qbit_d;
    logic [GATE_CONTEXT_ADDR_WIDTH-1:0]   ins_q,       ins_d;
    logic [CNT_WIDTH-1:0]                 tlim_q,      tlim_d;
    logic [CNT_WIDTH-1:0]                 cycles_q,    cycles_d;
    logic                                 err_q,       err_d;
    logic                                 tmo_q,       tmo_d;
    logic [GATE_CONTEXT_ADDR_WIDTH-1:0]   ctx_idx_q,   ctx_idx_d;
    logic [STATE_ADDR_WIDTH-1:0]          st_idx_q,    st_idx_d;
    logic                                 res_valid_q, res_valid_d;
    logic [STATE_ADDR_WIDTH-1:0]          res_addr_q,  res_addr_d;

    logic                                 w_q_bad;
    logic [MAX_QBIT_WIDTH-1:0]            w_shamt;
    logic [STATE_ADDR_WIDTH-1:0]          w_last_idx;
    logic [GATE_CONTEXT_ADDR_WIDTH-1:0]   w_ctx_last;
    logic [CNT_WIDTH-1:0]                 w_cyc_inc;

    // Job parameter checks and derived terminal indices (N-1 = low q-2 bits set)
    always_comb begin
        w_q_bad    = (i_qbit_num < c_q_min) || (i_qbit_num > c_q_max);
        w_shamt    = qbit_q - c_q_min;
        w_last_idx = ~({STATE_ADDR_WIDTH{1'b1}} << w_shamt);
        w_ctx_last = ins_q - c_ctx_one;
        w_cyc_inc  = (&cycles_q) ? cycles_q : cycles_q + c_cnt_one;
    end

    // Next-state logic and RAM / control outputs
    always_comb begin
        state_d       = state_q;
        qbit_d        = qbit_q;
        ins_d         = ins_q;
        tlim_d        = tlim_q;
        cycles_d      = cycles_q;
        err_d         = err_q;
        tmo_d         = tmo_q;
        ctx_idx_d     = ctx_idx_q;
        st_idx_d      = st_idx_q;
        res_valid_d   = 1'b0;
        res_addr_d    = '0;
        o_ctx_ready   = 1'b0;
        o_ctx_en      = 1'b0;
        o_ctx_wea     = 1'b0;
        o_ctx_addr    = '0;
        o_ctx_data    = '0;
        o_state_ena   = '0;
        o_state_wea   = '0;
        o_state_addra = '0;
        o_state_dina  = '0;
        o_qea_start   = 1'b0;
        o_done        = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (i_run) begin
                    qbit_d    = i_qbit_num;
                    ins_d     = i_ins_num;
                    tlim_d    = i_timeout;
                    cycles_d  = '0;
                    err_d     = 1'b0;
                    tmo_d     = 1'b0;
                    ctx_idx_d = '0;
                    st_idx_d  = '0;
                    if (w_q_bad) begin
                        err_d   = 1'b1;
                        state_d = S_ERR;
                    end else if (i_ins_num == '0) begin
                        state_d = S_LOAD_STATE;
                    end else begin
                        state_d = S_LOAD_CTX;
                    end
                end
            end
            S_LOAD_CTX: begin
                o_ctx_ready = 1'b1;
                if (i_ctx_valid) begin
                    o_ctx_en   = 1'b1;
                    o_ctx_wea  = 1'b1;
                    o_ctx_addr = ctx_idx_q;
                    o_ctx_data = i_ctx_data;
                    if (ctx_idx_q == w_ctx_last) begin
                        ctx_idx_d = '0;
                        state_d   = S_LOAD_STATE;
                    end else begin
                        ctx_idx_d = ctx_idx_q + c_ctx_one;
                    end
                end
            end
            S_LOAD_STATE: begin
                o_state_ena   = '1;
                o_state_wea   = '1;
                o_state_addra = st_idx_q;
                o_state_dina  = (st_idx_q == '0) ? c_one_word : '0;
                if (st_idx_q == w_last_idx) begin
                    st_idx_d = '0;
                    state_d  = S_START;
                end else begin
                    st_idx_d = st_idx_q + c_st_one;
                end
            end
            S_START: begin
                o_qea_start = 1'b1;
                state_d     = S_WAIT;
            end
            S_WAIT: begin
                cycles_d = w_cyc_inc;
                // completion takes priority over a limit reached on the same cycle
                if (i_qea_complete) begin
                    state_d = S_READ;
                end else if ((tlim_q != '0) && (w_cyc_inc == tlim_q)) begin
                    tmo_d   = 1'b1;
                    state_d = S_ERR;
                end
            end
            S_READ: begin
                o_state_ena   = '1;
                o_state_addra = st_idx_q;
                res_valid_d   = 1'b1;
                res_addr_d    = st_idx_q;
                if (st_idx_q == w_last_idx) begin
                    st_idx_d = '0;
                    state_d  = S_DRAIN;
                end else begin
                    st_idx_d = st_idx_q + c_st_one;
                end
            end
            S_DRAIN: begin
                state_d = S_DONE;
            end
            S_DONE: begin
                o_done  = 1'b1;
                state_d = S_IDLE;
            end
            S_ERR: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and job registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            qbit_q      <= '0;
            ins_q       <= '0;
            tlim_q      <= '0;
            cycles_q    <= '0;
            err_q       <= 1'b0;
            tmo_q       <= 1'b0;
            ctx_idx_q   <= '0;
            st_idx_q    <= '0;
            res_valid_q <= 1'b0;
            res_addr_q  <= '0;
        end else begin
            state_q     <= state_d;
            qbit_q      <= qbit_d;
            ins_q       <= ins_d;
            tlim_q      <= tlim_d;
            cycles_q    <= cycles_d;
            err_q       <= err_d;
            tmo_q       <= tmo_d;
            ctx_idx_q   <= ctx_idx_d;
            st_idx_q    <= st_idx_d;
            res_valid_q <= res_valid_d;
            res_addr_q  <= res_addr_d;
        end
    end

    // Status outputs; readback data is the RAM output one cycle after its address
    always_comb begin
        o_busy         = (state_q != S_IDLE);
        o_err          = err_q;
        o_timeout      = tmo_q;
        o_cycles       = cycles_q;
        o_qea_qbit_num = qbit_q;
        o_res_valid    = res_valid_q;
        o_res_addr     = res_addr_q;
        o_res_data     = res_valid_q ? i_state_dout : '0;
    end

endmodule
`default_nettype wire
